mips_fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. Owns the program counter, drives the instruction-memory address, captures the returned word into the IF/ID register, and handles stall, branch/jump-register redirect and squash requests from the decode stage. It sits directly upstream of decode and feeds it one instruction and its PC+4 per cycle.

---
 rtl/mips_fetch_stage_if.sv | 31 +++
 rtl/mips_fetch_stage.sv | 89 ++++++++
 tb/tb_mips_fetch_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, decode redirect/stall inputs,
// IF/ID register outputs and status/performance outputs.
interface mips_fetch_stage_if #(
   parameter int unsigned CNT_W = 16
);
   logic [31:0]      PC;
   logic [31:0]      Inst;
   logic             stall;
   logic             br_taken;
   logic [31:0]      br_target;
   logic             jr_taken;
   logic [31:0]      jr_target;
   logic [31:0]      ifid_inst;
   logic [31:0]      ifid_pc4;
   logic             ifid_valid;
   logic             misalign;
   logic [CNT_W-1:0] fetch_cnt;
   logic [CNT_W-1:0] squash_cnt;

   // Fetch-stage side
   modport master (
      output PC, ifid_inst, ifid_pc4, ifid_valid, misalign, fetch_cnt, squash_cnt,
      input  Inst, stall, br_taken, br_target, jr_taken, jr_target
   );

   // Memory / decode side
   modport slave (
      input  PC, ifid_inst, ifid_pc4, ifid_valid, misalign, fetch_cnt, squash_cnt,
      output Inst, stall, br_taken, br_target, jr_taken, jr_target
   );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: program counter, IF/ID pipeline register,
// redirect/squash handling and saturating fetch/squash counters.
module mips_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic               clock,
   input  logic               reset,
   mips_fetch_stage_if.master bus
);
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      ifid_inst_q, ifid_inst_d;
   logic [31:0]      ifid_pc4_q, ifid_pc4_d;
   logic             ifid_valid_q, ifid_valid_d;
   logic             misalign_q, misalign_d;
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

   logic [31:0] pc_plus4;
   logic        redirect;
   logic [31:0] raw_target;

   assign pc_plus4   = pc_q + 32'd4;
   assign redirect   = bus.jr_taken | bus.br_taken;
   // jr wins if decode ever asserts both
   assign raw_target = bus.jr_taken ? bus.jr_target : bus.br_target;

   // Next-state: redirect beats stall beats sequential fetch
   always_comb begin
      pc_d         = pc_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      misalign_d   = misalign_q;
      fetch_cnt_d  = fetch_cnt_q;
      squash_cnt_d = squash_cnt_q;

      if (redirect) begin
         pc_d         = {raw_target[31:2], 2'b00};
         ifid_inst_d  = 32'h0;
         ifid_pc4_d   = 32'h0;
         ifid_valid_d = 1'b0;
         misalign_d   = misalign_q | (|raw_target[1:0]);
         if (squash_cnt_q != CntMax) begin
            squash_cnt_d = squash_cnt_q + CntOne;
         end
      end else if (!bus.stall) begin
         pc_d         = pc_plus4;
         ifid_inst_d  = bus.Inst;
         ifid_pc4_d   = pc_plus4;
         ifid_valid_d = 1'b1;
         if (fetch_cnt_q != CntMax) begin
            fetch_cnt_d = fetch_cnt_q + CntOne;
         end
      end
   end

   // State register with asynchronous active-high reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         ifid_inst_q  <= 32'h0;
         ifid_pc4_q   <= 32'h0;
         ifid_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         fetch_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         pc_q         <= pc_d;
         ifid_inst_q  <= ifid_inst_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
         misalign_q   <= misalign_d;
         fetch_cnt_q  <= fetch_cnt_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end

   assign bus.PC         = pc_q;
   assign bus.ifid_inst  = ifid_inst_q;
   assign bus.ifid_pc4   = ifid_pc4_q;
   assign bus.ifid_valid = ifid_valid_q;
   assign bus.misalign   = misalign_q;
   assign bus.fetch_cnt  = fetch_cnt_q;
   assign bus.squash_cnt = squash_cnt_q;
endmodule

// File: tb/tb_mips_fetch_stage.sv
// Randomized bench for mips_fetch_stage: two instances (16-bit and 4-bit
// counters) share stimulus and are compared against a behavioural model.
module tb_mips_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall, br_taken, jr_taken;
   logic [31:0] br_target, jr_target;

   int n_cmp = 0;
   int n_bad = 0;

   mips_fetch_stage_if #(.CNT_W(16)) bus_a ();
   mips_fetch_stage_if #(.CNT_W(4))  bus_b ();

   mips_fetch_stage #(.RESET_PC(RESET_PC), .CNT_W(16)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );
   mips_fetch_stage #(.RESET_PC(RESET_PC), .CNT_W(4)) u_dut_small (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b)
   );

   // Instruction memory: a fixed scramble of the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign bus_a.Inst      = mem_word(bus_a.PC);
   assign bus_b.Inst      = mem_word(bus_b.PC);
   assign bus_a.stall     = stall;
   assign bus_b.stall     = stall;
   assign bus_a.br_taken  = br_taken;
   assign bus_b.br_taken  = br_taken;
   assign bus_a.br_target = br_target;
   assign bus_b.br_target = br_target;
   assign bus_a.jr_taken  = jr_taken;
   assign bus_b.jr_taken  = jr_taken;
   assign bus_a.jr_target = jr_target;
   assign bus_b.jr_target = jr_target;

   always #5 clock = ~clock;

   // Behavioural model state; counters kept unbounded and clipped on compare
   logic [31:0] m_pc, m_inst, m_pc4;
   logic        m_valid, m_mis;
   int          m_fetch, m_squash;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] clip(input int v, input int maxv);
      return (v > maxv) ? 32'(maxv) : 32'(v);
   endfunction

   task automatic model_reset();
      m_pc = RESET_PC; m_inst = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
      m_fetch = 0; m_squash = 0;
   endtask

   task automatic model_edge();
      logic [31:0] t;
      if (jr_taken || br_taken) begin
         t = jr_taken ? jr_target : br_target;
         if (t % 4 != 0) m_mis = 1'b1;
         m_pc = t - (t % 4);
         m_inst = 0; m_pc4 = 0; m_valid = 0;
         m_squash++;
      end else if (!stall) begin
         m_inst  = mem_word(m_pc);
         m_pc    = m_pc + 32'd4;
         m_pc4   = m_pc;
         m_valid = 1'b1;
         m_fetch++;
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".pc"},     bus_a.PC, m_pc);
      check_eq({tag, ".inst"},   bus_a.ifid_inst, m_inst);
      check_eq({tag, ".pc4"},    bus_a.ifid_pc4, m_pc4);
      check_eq({tag, ".valid"},  32'(bus_a.ifid_valid), 32'(m_valid));
      check_eq({tag, ".mis"},    32'(bus_a.misalign), 32'(m_mis));
      check_eq({tag, ".fcnt"},   32'(bus_a.fetch_cnt), clip(m_fetch, 65535));
      check_eq({tag, ".scnt"},   32'(bus_a.squash_cnt), clip(m_squash, 65535));
      check_eq({tag, ".fcnt4"},  32'(bus_b.fetch_cnt), clip(m_fetch, 15));
      check_eq({tag, ".scnt4"},  32'(bus_b.squash_cnt), clip(m_squash, 15));
      check_eq({tag, ".pc_b"},   bus_b.PC, m_pc);
   endtask

   task automatic set_in(input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
      stall = s; br_taken = b; br_target = bt; jr_taken = j; jr_target = jt;
   endtask

   // One edge: model samples inputs at the edge, DUT outputs checked 1 later
   task automatic step(input string tag);
      @(posedge clock);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Called 1 time unit after an edge; reset pulse lies wholly between edges
   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      #1 reset = 1'b0;
      set_in(0, 0, 0, 0, 0);
   endtask

   initial begin
      int guard;
      logic [31:0] t;
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0);
      model_reset();
      #2 check_all("reset");
      #1 reset = 1'b0;

      // Free run: PC 0,4,..,20
      for (int i = 0; i < 5; i++) step("run");
      check_eq("run5_fcnt", 32'(bus_a.fetch_cnt), 32'd5);

      // Advance to 0x20 then stall 3 cycles
      guard = 0;
      while (m_pc != 32'h20 && guard < 40) begin step("to20"); guard++; end
      set_in(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("stall");
      check_eq("stall_pc", bus_a.PC, 32'h20);
      set_in(0, 0, 0, 0, 0);
      step("unstall");
      check_eq("unstall_pc", bus_a.PC, 32'h24);

      // Branch at 0x48 back to 0x20, then branch+stall
      guard = 0;
      while (m_pc != 32'h48 && guard < 40) begin step("to48"); guard++; end
      set_in(0, 1, 32'h20, 0, 0);
      step("br");
      check_eq("br_valid", 32'(bus_a.ifid_valid), 32'd0);
      set_in(0, 0, 0, 0, 0);
      step("br_next");
      set_in(1, 1, 32'h20, 0, 0);
      step("br_stall");
      check_eq("br_stall_pc", bus_a.PC, 32'h20);

      // jr and br together: jr wins, misaligned target flagged
      set_in(0, 1, 32'h40, 1, 32'h1E);
      step("jr_br");
      check_eq("jr_br_pc", bus_a.PC, 32'h1C);
      set_in(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("post_mis");

      // Wrap from 0xFFFFFFFC to 0
      set_in(0, 0, 0, 1, 32'hFFFF_FFFC);
      step("jr_top");
      set_in(0, 0, 0, 0, 0);
      step("wrap");
      check_eq("wrap_pc", bus_a.PC, 32'h0);
      for (int i = 0; i < 20; i++) step("sat");
      check_eq("sat_small", 32'(bus_b.fetch_cnt), 32'hF);

      // Randomized phase
      for (int i = 0; i < 600; i++) begin
         t = $urandom();
         if ($urandom_range(3) != 0) t[1:0] = 2'b00;
         set_in($urandom_range(99) < 30, $urandom_range(99) < 10, t,
                $urandom_range(99) < 5, {t[15:0], t[31:16]});
         step("rand");
         if ($urandom_range(79) == 0) async_reset("rand_rst");
      end

      // Async reset in the middle of a stall
      set_in(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("pre_rst");
      set_in(1, 0, 0, 0, 0);
      step("rst_stall");
      async_reset("mid_rst");
      check_eq("mid_rst_pc", bus_a.PC, RESET_PC);
      check_eq("mid_rst_valid", 32'(bus_a.ifid_valid), 32'd0);
      check_eq("mid_rst_fcnt", 32'(bus_a.fetch_cnt), 32'd0);
      step("after_rst");
      check_eq("after_rst_pc", bus_a.PC, RESET_PC + 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
